pkt_data_gen: RTL and testbench

Parametrised test-packet source for the UDP/IP transmit path. It generates a programmable number of packets of programmable byte length, DW bits per beat, on the vld/sop/eop/mty stream interface under downstream rdy backpressure. It supports three payload modes, a programmable inter-packet gap, continuous mode with graceful stop, and a completed-packet counter. It sits ahead of the UDP packer and replaces the fixed 26-beat, 16-bit generator.

---
 rtl/pkt_data_gen.sv | 192 +++++++++++++++++++
 tb/tb_pkt_data_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_data_gen.sv
// ============================================================================
// Module   : pkt_data_gen
// Brief    : Programmable test-packet source (increment/constant/LFSR payload)
// Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_data_gen #(
  parameter int DW    = 16,
  parameter int MTY_W = 1,
  parameter int LEN_W = 11,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [15:0]      cfg_num,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       cfg_seed,
  input  logic             rdy,
  output logic             busy,
  output logic [DW-1:0]    dout,
  output logic             dout_vld,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic [MTY_W-1:0] dout_mty,
  output logic [15:0]      pkt_cnt,
  output logic             done
);

  localparam int B = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] beats_q, beat_q;
  logic [MTY_W-1:0] mty_q;
  logic [15:0]      num_q;
  logic [GAP_W-1:0] gap_q, gap_cnt_q;
  logic [1:0]       mode_q;
  logic [7:0]       seed_q, cur_q;
  logic             stop_q;

  logic [DW-1:0]    dout_q;
  logic             vld_q, sop_q, eop_q, done_q;
  logic [MTY_W-1:0] dout_mty_q;
  logic [15:0]      pkt_cnt_q;

  // Packet geometry derived from the configuration at the start edge
  logic [LEN_W:0]   w_beats, w_pad;
  logic [7:0]       w_seed;
  assign w_beats = ({1'b0, cfg_len} + (LEN_W+1)'(B - 1)) / (LEN_W+1)'(B);
  assign w_pad   = w_beats * (LEN_W+1)'(B) - {1'b0, cfg_len};
  assign w_seed  = (cfg_mode == 2'd2 && cfg_seed == 8'h00) ? 8'hFF : cfg_seed;

  logic             w_last;
  logic [7:0]       w_base;
  logic [16:0]      w_cnt_inc;
  logic             w_end;
  assign w_last    = (beat_q == beats_q - LEN_W'(1));
  assign w_base    = (beat_q == '0) ? seed_q : cur_q;
  assign w_cnt_inc = {1'b0, pkt_cnt_q} + 17'd1;
  assign w_end     = ((num_q != 16'd0) && (w_cnt_inc == {1'b0, num_q})) || stop_q || stop;

  logic [DW-1:0]    dout_d;
  logic [7:0]       cur_d;

  // One beat of payload; cur_d is the first byte of the following beat
  always_comb begin
    logic [7:0] lfsr;
    logic [7:0] b;
    lfsr   = w_base;
    dout_d = '0;
    for (int k = 0; k < B; k++) begin
      case (mode_q)
        2'd1:    b = w_base;
        2'd2:    b = lfsr;
        default: b = w_base + 8'(k);
      endcase
      if (w_last && (k >= B - int'(mty_q))) b = 8'h00;
      dout_d[DW-1-8*k -: 8] = b;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    case (mode_q)
      2'd1:    cur_d = w_base;
      2'd2:    cur_d = lfsr;
      default: cur_d = w_base + 8'(B);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beats_q    <= '0;
      beat_q     <= '0;
      mty_q      <= '0;
      num_q      <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      mode_q     <= '0;
      seed_q     <= '0;
      cur_q      <= '0;
      stop_q     <= 1'b0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      dout_mty_q <= '0;
      pkt_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      dout_q     <= '0;
      vld_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      dout_mty_q <= '0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en && cfg_len != '0) begin
            beats_q   <= LEN_W'(w_beats);
            mty_q     <= MTY_W'(w_pad);
            num_q     <= cfg_num;
            gap_q     <= cfg_gap;
            mode_q    <= cfg_mode;
            seed_q    <= w_seed;
            beat_q    <= '0;
            stop_q    <= 1'b0;
            pkt_cnt_q <= '0;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (stop) stop_q <= 1'b1;
          if (rdy) begin
            dout_q <= dout_d;
            vld_q  <= 1'b1;
            sop_q  <= (beat_q == '0);
            cur_q  <= cur_d;
            if (w_last) begin
              eop_q      <= 1'b1;
              dout_mty_q <= mty_q;
              beat_q     <= '0;
              if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= w_cnt_inc[15:0];
              if (w_end) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
                stop_q  <= 1'b0;
              end else if (gap_q != '0) begin
                state_q   <= S_GAP;
                gap_cnt_q <= '0;
              end
            end else begin
              beat_q <= beat_q + LEN_W'(1);
            end
          end
        end
        S_GAP: begin
          if (stop || stop_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            stop_q  <= 1'b0;
          end else if (gap_cnt_q == gap_q - GAP_W'(1)) begin
            state_q <= S_SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign dout_sop = sop_q;
  assign dout_eop = eop_q;
  assign dout_mty = dout_mty_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_data_gen.sv
// ============================================================================
// Module   : tb_pkt_data_gen
// Brief    : Directed vector bench for pkt_data_gen (DW=16)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pkt_data_gen;

  localparam int DW = 16, MTY_W = 1, LEN_W = 11, GAP_W = 8;

  logic             clk, rst, en, stop, rdy;
  logic [LEN_W-1:0] cfg_len;
  logic [15:0]      cfg_num;
  logic [GAP_W-1:0] cfg_gap;
  logic [1:0]       cfg_mode;
  logic [7:0]       cfg_seed;
  logic             busy, dout_vld, dout_sop, dout_eop, done;
  logic [DW-1:0]    dout;
  logic [MTY_W-1:0] dout_mty;
  logic [15:0]      pkt_cnt;

  pkt_data_gen #(.DW(DW), .MTY_W(MTY_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .en(en), .stop(stop), .cfg_len(cfg_len), .cfg_num(cfg_num),
    .cfg_gap(cfg_gap), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .rdy(rdy),
    .busy(busy), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .dout_mty(dout_mty), .pkt_cnt(pkt_cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        sop, eop, mty, done;
    logic [15:0] cnt;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [10:0] len;
    logic [1:0]  mode;
    logic [7:0]  seed;
    int          beats;
    logic [15:0] first, last;
    logic        mty;
  } vec_t;

  int    n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
  beat_t q[$];
  vec_t  vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    beat_t b;
    @(negedge clk);
    cyc++;
    if (dout_vld) begin
      b.data = dout; b.sop = dout_sop; b.eop = dout_eop; b.mty = dout_mty;
      b.done = done; b.cnt = pkt_cnt; b.cyc = cyc;
      q.push_back(b);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic start(input logic [10:0] len, input logic [15:0] num, input logic [7:0] gap,
                       input logic [1:0] mode, input logic [7:0] seed);
    q.delete();
    done_cnt = 0;
    cfg_len = len; cfg_num = num; cfg_gap = gap; cfg_mode = mode; cfg_seed = seed;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [7:0] m_byte(input logic [1:0] mode, input logic [7:0] seed, input int k);
    logic [7:0] s;
    s = (mode == 2'd2 && seed == 8'h00) ? 8'hFF : seed;
    if (mode == 2'd1) return seed;
    if (mode == 2'd2) begin
      for (int i = 0; i < k; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      return s;
    end
    return seed + 8'(k);
  endfunction

  function automatic logic [15:0] m_beat(input logic [1:0] mode, input logic [7:0] seed,
                                         input int len, input int idx);
    logic [7:0] hi, lo;
    hi = (2*idx     < len) ? m_byte(mode, seed, 2*idx)     : 8'h00;
    lo = (2*idx + 1 < len) ? m_byte(mode, seed, 2*idx + 1) : 8'h00;
    return {hi, lo};
  endfunction

  // Compares every captured beat of a single packet against the payload model
  task automatic chk_pkt(input string name, input logic [1:0] mode, input logic [7:0] seed,
                         input int len, input int first);
    int bad = 0;
    int nb = (len + 1) / 2;
    for (int i = 0; i < nb; i++) begin
      if (first + i >= q.size()) bad++;
      else begin
        if (q[first+i].data !== m_beat(mode, seed, len, i)) bad++;
        if (q[first+i].sop !== (i == 0)) bad++;
        if (q[first+i].eop !== (i == nb - 1)) bad++;
      end
    end
    chk({name, "_model"}, bad, 0);
  endtask

  initial begin
    vecs[0] = '{11'd26, 2'd0, 8'h41, 13, 16'h4142, 16'h595A, 1'b0};
    vecs[1] = '{11'd5,  2'd0, 8'h41, 3,  16'h4142, 16'h4500, 1'b1};
    vecs[2] = '{11'd1,  2'd0, 8'h41, 1,  16'h4100, 16'h4100, 1'b1};
    vecs[3] = '{11'd4,  2'd1, 8'hA5, 2,  16'hA5A5, 16'hA5A5, 1'b0};
    vecs[4] = '{11'd3,  2'd2, 8'h00, 2,  16'hFFFE, 16'hFC00, 1'b1};
    vecs[5] = '{11'd4,  2'd2, 8'h01, 2,  16'h0102, 16'h0408, 1'b0};
    vecs[6] = '{11'd3,  2'd0, 8'hFE, 2,  16'hFEFF, 16'h0000, 1'b1};
    vecs[7] = '{11'd7,  2'd3, 8'h10, 4,  16'h1011, 16'h1600, 1'b1};
    vecs[8] = '{11'd2,  2'd2, 8'h80, 1,  16'h8001, 16'h8001, 1'b0};

    rst = 1'b1; en = 1'b0; stop = 1'b0; rdy = 1'b1;
    cfg_len = '0; cfg_num = '0; cfg_gap = '0; cfg_mode = '0; cfg_seed = '0;
    repeat (3) tick();
    chk("rst_vld", dout_vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", pkt_cnt, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Zero length start is ignored
    cfg_len = '0; en = 1'b1;
    tick();
    en = 1'b0;
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_vld", dout_vld, 0);

    // Single packets from the vector table
    for (int v = 0; v < 9; v++) begin
      start(vecs[v].len, 16'd1, 8'd0, vecs[v].mode, vecs[v].seed);
      wait_done(100);
      chk($sformatf("v%0d_done", v), done_cnt, 1);
      chk($sformatf("v%0d_beats", v), q.size(), vecs[v].beats);
      if (q.size() != 0) begin
        chk($sformatf("v%0d_first", v), q[0].data, vecs[v].first);
        chk($sformatf("v%0d_last", v), q[$].data, vecs[v].last);
        chk($sformatf("v%0d_mty", v), q[$].mty, vecs[v].mty);
        chk($sformatf("v%0d_cnt", v), q[$].cnt, 1);
        chk($sformatf("v%0d_eopdone", v), q[$].done, 1);
        chk($sformatf("v%0d_contig", v), q[$].cyc - q[0].cyc, vecs[v].beats - 1);
      end
      chk_pkt($sformatf("v%0d", v), vecs[v].mode, vecs[v].seed, int'(vecs[v].len), 0);
      tick();
      chk($sformatf("v%0d_busy", v), busy, 0);
    end

    // Backpressure: vld follows rdy by one cycle
    begin
      bit in_send = 1'b1;
      int issued = 0, bad = 0;
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit exp_vld;
      start(11'd26, 16'd1, 8'd0, 2'd0, 8'h41);
      for (int i = 0; i < 70; i++) begin
        rdy = pat[i % 4];
        exp_vld = in_send && rdy;
        if (exp_vld) begin
          issued++;
          if (issued == 13) in_send = 1'b0;
        end
        tick();
        if (dout_vld !== exp_vld) bad++;
      end
      rdy = 1'b1;
      chk("bp_vld_pattern", bad, 0);
      chk("bp_beats", q.size(), 13);
      chk("bp_done", done_cnt, 1);
      chk_pkt("bp", 2'd0, 8'h41, 26, 0);
    end

    // Three packets with a 4-cycle gap
    start(11'd4, 16'd3, 8'd4, 2'd0, 8'h00);
    wait_done(200);
    repeat (10) tick();
    chk("gap_beats", q.size(), 6);
    chk("gap_done", done_cnt, 1);
    if (q.size() == 6) begin
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("gap_cnt%0d", p), q[2*p+1].cnt, p + 1);
        chk_pkt($sformatf("gap_p%0d", p), 2'd0, 8'h00, 4, 2*p);
      end
      chk("gap_space0", q[2].cyc - q[1].cyc, 5);
      chk("gap_space1", q[4].cyc - q[3].cyc, 5);
      chk("gap_lastdone", q[5].done, 1);
    end

    // Continuous mode, stop during beat 2 of packet 5, en while busy
    begin
      bit stopped = 1'b0;
      int bad = 0;
      start(11'd6, 16'd0, 8'd0, 2'd1, 8'hA5);
      for (int n = 0; n < 200 && done_cnt == 0; n++) begin
        tick();
        en = (q.size() == 5);
        if (q.size() == 5) cfg_len = 11'd2;
        stop = (q.size() == 13 && !stopped);
        if (stop) stopped = 1'b1;
      end
      en = 1'b0; stop = 1'b0;
      chk("cont_done", done_cnt, 1);
      chk("cont_beats", q.size(), 15);
      if (q.size() == 15) begin
        chk("cont_cnt", q[14].cnt, 5);
        chk("cont_eop", q[14].eop, 1);
        chk("cont_mty", q[14].mty, 0);
      end
      for (int i = 0; i < q.size(); i++) if (q[i].data !== 16'hA5A5) bad++;
      chk("cont_data", bad, 0);
      tick();
      chk("cont_busy", busy, 0);
    end

    // Stop while in the inter-packet gap
    start(11'd2, 16'd0, 8'd10, 2'd0, 8'h20);
    for (int n = 0; n < 20 && q.size() == 0; n++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("gstop_done", done_cnt, 1);
    chk("gstop_when", done_cyc - q[0].cyc, 1);
    chk("gstop_busy", busy, 0);
    chk("gstop_cnt", pkt_cnt, 1);
    repeat (12) tick();
    chk("gstop_beats", q.size(), 1);

    // Reset mid-packet, then restart in LFSR mode with seed 0
    start(11'd26, 16'd1, 8'd0, 2'd2, 8'h00);
    for (int n = 0; n < 50 && q.size() < 6; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_vld", dout_vld, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_eop", dout_eop, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done_cnt, 0);
    chk("mrst_first", q[0].data, 16'hFFFE);
    tick();
    start(11'd4, 16'd1, 8'd0, 2'd2, 8'h00);
    wait_done(50);
    chk("rs_beats", q.size(), 2);
    if (q.size() == 2) begin
      chk("rs_sop", q[0].sop, 1);
      chk("rs_b0", q[0].data, 16'hFFFE);
      chk("rs_b1", q[1].data, 16'hFCF8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
